// File: rtl/lu_pkg.sv
// Shared types for the LU matrix store: complex element/row layout, store states
// and host read selectors.
package lu_pkg;
    localparam int LU_SIZE  = 4;
    localparam int LU_WIDTH = 64;

    typedef struct packed {
        logic [LU_WIDTH-1:0] imag;
        logic [LU_WIDTH-1:0] re;
    } cplx_t;

    typedef cplx_t [LU_SIZE-1:0] row_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } store_state_e;

    typedef enum logic [1:0] {
        SEL_MAT  = 2'd0,
        SEL_L    = 2'd1,
        SEL_U    = 2'd2,
        SEL_RSVD = 2'd3
    } rd_sel_e;
endpackage

// File: rtl/lu_mat_store_if.sv
// Host, engine and control signals of the LU matrix store; slave = store side,
// master = host/engine side.
interface lu_mat_store_if #(
    parameter int SIZE  = 4,
    parameter int WIDTH = 64
);
    localparam int AW = $clog2(SIZE);
    localparam int RW = SIZE * 2 * WIDTH;

    logic          host_wr_valid_i;
    logic          host_wr_ready_o;
    logic [AW-1:0] host_wr_addr_i;
    logic [RW-1:0] host_wr_row_i;
    logic          host_rd_valid_i;
    logic          host_rd_ready_o;
    logic [1:0]    host_rd_sel_i;
    logic [AW-1:0] host_rd_addr_i;
    logic [RW-1:0] host_rd_row_o;
    logic          host_rd_row_valid_o;
    logic          go_i;
    logic          clear_i;
    logic          abort_i;
    logic          lu_start_o;
    logic          lu_flush_o;
    logic [AW-1:0] mat_row_read_addr_i;
    logic          mat_row_read_addr_valid_i;
    logic [RW-1:0] mat_row_o;
    logic          mat_row_valid_o;
    logic [AW-1:0] mat_row_addr_o;
    logic [RW-1:0] mat_row_i;
    logic          mat_row_valid_i;
    logic [AW-1:0] mat_row_write_addr_i;
    logic          mat_row_out_ready_o;
    logic [RW-1:0] l_col_i;
    logic [RW-1:0] u_row_i;
    logic [AW-1:0] result_addr_i;
    logic          result_valid_i;
    logic          result_out_ready_o;
    logic          busy_o;
    logic          done_o;

    modport slave (
        input  host_wr_valid_i, host_wr_addr_i, host_wr_row_i,
        input  host_rd_valid_i, host_rd_sel_i, host_rd_addr_i,
        input  go_i, clear_i, abort_i,
        input  mat_row_read_addr_i, mat_row_read_addr_valid_i,
        input  mat_row_i, mat_row_valid_i, mat_row_write_addr_i,
        input  l_col_i, u_row_i, result_addr_i, result_valid_i,
        output host_wr_ready_o, host_rd_ready_o, host_rd_row_o, host_rd_row_valid_o,
        output lu_start_o, lu_flush_o, mat_row_o, mat_row_valid_o, mat_row_addr_o,
        output mat_row_out_ready_o, result_out_ready_o, busy_o, done_o
    );

    modport master (
        output host_wr_valid_i, host_wr_addr_i, host_wr_row_i,
        output host_rd_valid_i, host_rd_sel_i, host_rd_addr_i,
        output go_i, clear_i, abort_i,
        output mat_row_read_addr_i, mat_row_read_addr_valid_i,
        output mat_row_i, mat_row_valid_i, mat_row_write_addr_i,
        output l_col_i, u_row_i, result_addr_i, result_valid_i,
        input  host_wr_ready_o, host_rd_ready_o, host_rd_row_o, host_rd_row_valid_o,
        input  lu_start_o, lu_flush_o, mat_row_o, mat_row_valid_o, mat_row_addr_o,
        input  mat_row_out_ready_o, result_out_ready_o, busy_o, done_o
    );
endinterface

// File: rtl/lu_row_bank.sv
// Register array of ROWS rows with one registered read port and one write port;
// a same-address read and write in one cycle returns the old row.
module lu_row_bank #(
    parameter int ROWS = 4,
    parameter int DW   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rd_en,
    input  logic [$clog2(ROWS)-1:0] rd_addr,
    output logic [DW-1:0]           rd_data,
    input  logic                    wr_en,
    input  logic [$clog2(ROWS)-1:0] wr_addr,
    input  logic [DW-1:0]           wr_data
);
    logic [DW-1:0] mem [ROWS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ROWS; i++) mem[i] <= '0;
            rd_data <= '0;
        end else begin
            if (rd_en) rd_data <= mem[rd_addr];
            if (wr_en) mem[wr_addr] <= wr_data;
        end
    end
endmodule

// File: rtl/lu_mat_store.sv
// Matrix/L/U storage behind the LU engine row interface, with host load/readback.
// state | meaning:  IDLE host loads rows | RUN engine owns ports | DONE host readback
module lu_mat_store
    import lu_pkg::*;
#(
    parameter int SIZE  = LU_SIZE,
    parameter int WIDTH = LU_WIDTH
) (
    input  logic clk_i,
    input  logic rst_i,
    lu_mat_store_if.slave bus
);
    localparam int AW = $clog2(SIZE);
    localparam int RW = SIZE * 2 * WIDTH;

    store_state_e  state;
    logic [SIZE-1:0] load_mask, result_mask, result_hit, result_next;
    logic idle_st, run_st, done_st, run_stay;
    logic host_wr_fire, host_rd_fire, eng_rd_fire, eng_wr_fire;
    logic start_q, flush_q, busy_q, done_q, wr_ready_q, rd_ready_q;

    logic [RW-1:0] mat_rd, l_rd, u_rd, mat_hold_q, host_row;
    logic [AW-1:0] eng_addr_q;
    logic [1:0]    host_sel_q;
    logic          eng_valid_q, host_valid_q;

    assign idle_st      = (state == ST_IDLE);
    assign run_st       = (state == ST_RUN);
    assign done_st      = (state == ST_DONE);
    assign result_hit   = (run_st && bus.result_valid_i) ? (SIZE'(1) << bus.result_addr_i) : '0;
    assign result_next  = result_mask | result_hit;
    // Engine reads issued in the last RUN cycle would surface outside RUN, so drop them.
    assign run_stay     = run_st && !bus.abort_i && !(&result_next);
    assign host_wr_fire = idle_st && bus.host_wr_valid_i;
    assign host_rd_fire = (idle_st || done_st) && bus.host_rd_valid_i;
    assign eng_rd_fire  = run_stay && bus.mat_row_read_addr_valid_i;
    assign eng_wr_fire  = run_st && bus.mat_row_valid_i;

    lu_row_bank #(.ROWS(SIZE), .DW(RW)) u_mat (
        .clk(clk_i), .rst(rst_i),
        .rd_en(eng_rd_fire || host_rd_fire),
        .rd_addr(run_st ? bus.mat_row_read_addr_i : bus.host_rd_addr_i),
        .rd_data(mat_rd),
        .wr_en(host_wr_fire || eng_wr_fire),
        .wr_addr(run_st ? bus.mat_row_write_addr_i : bus.host_wr_addr_i),
        .wr_data(run_st ? bus.mat_row_i : bus.host_wr_row_i)
    );

    lu_row_bank #(.ROWS(SIZE), .DW(RW)) u_l (
        .clk(clk_i), .rst(rst_i),
        .rd_en(host_rd_fire), .rd_addr(bus.host_rd_addr_i), .rd_data(l_rd),
        .wr_en(run_st && bus.result_valid_i), .wr_addr(bus.result_addr_i), .wr_data(bus.l_col_i)
    );

    lu_row_bank #(.ROWS(SIZE), .DW(RW)) u_u (
        .clk(clk_i), .rst(rst_i),
        .rd_en(host_rd_fire), .rd_addr(bus.host_rd_addr_i), .rd_data(u_rd),
        .wr_en(run_st && bus.result_valid_i), .wr_addr(bus.result_addr_i), .wr_data(bus.u_row_i)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            load_mask   <= '0;
            result_mask <= '0;
            start_q     <= 1'b0;
            flush_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wr_ready_q  <= 1'b1;
            rd_ready_q  <= 1'b1;
        end else begin
            start_q <= 1'b0;
            flush_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (host_wr_fire) load_mask[bus.host_wr_addr_i] <= 1'b1;
                    if (bus.go_i && (&load_mask)) begin
                        state       <= ST_RUN;
                        start_q     <= 1'b1;
                        result_mask <= '0;
                        busy_q      <= 1'b1;
                        wr_ready_q  <= 1'b0;
                        rd_ready_q  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (bus.abort_i) begin
                        state       <= ST_IDLE;
                        flush_q     <= 1'b1;
                        result_mask <= '0;
                        busy_q      <= 1'b0;
                        wr_ready_q  <= 1'b1;
                        rd_ready_q  <= 1'b1;
                    end else begin
                        result_mask <= result_next;
                        if (&result_next) begin
                            state      <= ST_DONE;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            rd_ready_q <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.clear_i) begin
                        state       <= ST_IDLE;
                        load_mask   <= '0;
                        result_mask <= '0;
                        done_q      <= 1'b0;
                        wr_ready_q  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // The MAT read port is shared with the host, so the engine-facing row is held here.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            eng_valid_q  <= 1'b0;
            eng_addr_q   <= '0;
            mat_hold_q   <= '0;
            host_valid_q <= 1'b0;
            host_sel_q   <= '0;
        end else begin
            eng_valid_q  <= eng_rd_fire;
            host_valid_q <= host_rd_fire;
            if (eng_rd_fire)  eng_addr_q <= bus.mat_row_read_addr_i;
            if (eng_valid_q)  mat_hold_q <= mat_rd;
            if (host_rd_fire) host_sel_q <= bus.host_rd_sel_i;
        end
    end

    always_comb begin
        host_row = '0;
        if (host_valid_q) begin
            case (rd_sel_e'(host_sel_q))
                SEL_MAT: host_row = mat_rd;
                SEL_L:   host_row = l_rd;
                SEL_U:   host_row = u_rd;
                default: host_row = '0;
            endcase
        end
    end

    assign bus.host_wr_ready_o     = wr_ready_q;
    assign bus.host_rd_ready_o     = rd_ready_q;
    assign bus.host_rd_row_o       = host_row;
    assign bus.host_rd_row_valid_o = host_valid_q;
    assign bus.lu_start_o          = start_q;
    assign bus.lu_flush_o          = flush_q;
    assign bus.mat_row_o           = eng_valid_q ? mat_rd : mat_hold_q;
    assign bus.mat_row_valid_o     = eng_valid_q;
    assign bus.mat_row_addr_o      = eng_addr_q;
    assign bus.mat_row_out_ready_o = busy_q;
    assign bus.result_out_ready_o  = busy_q;
    assign bus.busy_o              = busy_q;
    assign bus.done_o              = done_q;
endmodule

// File: tb/tb_lu_mat_store.sv
// Scoreboard bench for lu_mat_store: host and engine read results are queued at
// issue time from a reference model and compared when the DUT returns them.
module tb_lu_mat_store;
    import lu_pkg::*;

    localparam int SIZE  = 4;
    localparam int WIDTH = 64;
    localparam int AW    = $clog2(SIZE);
    localparam int RW    = SIZE * 2 * WIDTH;

    typedef logic [RW-1:0] rowv_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lu_mat_store_if #(.SIZE(SIZE), .WIDTH(WIDTH)) bus ();
    lu_mat_store #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (.clk_i(clk), .rst_i(rst), .bus(bus.slave));

    int checks = 0;
    int failures = 0;
    rowv_t m_mat [SIZE];
    rowv_t m_l   [SIZE];
    rowv_t m_u   [SIZE];
    rowv_t host_q [$];
    rowv_t eng_q  [$];
    rowv_t eng_aq [$];

    task automatic chk(input string tag, input rowv_t obs, input rowv_t exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic rowv_t mk_row(input int i);
        row_t r;
        for (int j = 0; j < SIZE; j++) begin
            r[j].re   = 64'(i * 4 + j);
            r[j].imag = 64'(-(i * 4 + j));
        end
        return rowv_t'(r);
    endfunction

    function automatic rowv_t rand_row();
        rowv_t r;
        for (int k = 0; k < RW / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input int a, input rowv_t r);
        bus.host_wr_valid_i = 1'b1;
        bus.host_wr_addr_i  = AW'(a);
        bus.host_wr_row_i   = r;
        m_mat[a] = r;
        tick();
        bus.host_wr_valid_i = 1'b0;
    endtask

    task automatic host_read(input int sel, input int a);
        rowv_t e;
        case (sel)
            0:       e = m_mat[a];
            1:       e = m_l[a];
            2:       e = m_u[a];
            default: e = '0;
        endcase
        host_q.push_back(e);
        bus.host_rd_valid_i = 1'b1;
        bus.host_rd_sel_i   = 2'(sel);
        bus.host_rd_addr_i  = AW'(a);
        tick();
        bus.host_rd_valid_i = 1'b0;
    endtask

    task automatic eng_read(input int a);
        eng_q.push_back(m_mat[a]);
        eng_aq.push_back(rowv_t'(a));
        bus.mat_row_read_addr_valid_i = 1'b1;
        bus.mat_row_read_addr_i       = AW'(a);
    endtask

    task automatic send_result(input int a);
        rowv_t l, u;
        l = rand_row();
        u = rand_row();
        m_l[a] = l;
        m_u[a] = u;
        bus.result_valid_i = 1'b1;
        bus.result_addr_i  = AW'(a);
        bus.l_col_i        = l;
        bus.u_row_i        = u;
        tick();
        bus.result_valid_i = 1'b0;
    endtask

    task automatic go_pulse();
        bus.go_i = 1'b1;
        tick();
        bus.go_i = 1'b0;
    endtask

    always @(posedge clk) begin
        #1;
        if (bus.host_rd_row_valid_o === 1'b1) begin
            chk("host_rd_expected", rowv_t'(host_q.size() != 0), rowv_t'(1));
            if (host_q.size() != 0) chk("host_rd_row", bus.host_rd_row_o, host_q.pop_front());
        end
        if (bus.mat_row_valid_o === 1'b1) begin
            chk("eng_rd_expected", rowv_t'(eng_q.size() != 0), rowv_t'(1));
            if (eng_q.size() != 0) begin
                chk("eng_rd_row", bus.mat_row_o, eng_q.pop_front());
                chk("eng_rd_addr", rowv_t'(bus.mat_row_addr_o), eng_aq.pop_front());
            end
        end
    end

    initial begin
        int seq [5];
        rowv_t aa, nr;
        seq = '{3, 0, 2, 0, 1};
        aa = {64{8'hAA}};
        bus.host_wr_valid_i = 1'b0; bus.host_wr_addr_i = '0; bus.host_wr_row_i = '0;
        bus.host_rd_valid_i = 1'b0; bus.host_rd_sel_i = '0; bus.host_rd_addr_i = '0;
        bus.go_i = 1'b0; bus.clear_i = 1'b0; bus.abort_i = 1'b0;
        bus.mat_row_read_addr_i = '0; bus.mat_row_read_addr_valid_i = 1'b0;
        bus.mat_row_i = '0; bus.mat_row_valid_i = 1'b0; bus.mat_row_write_addr_i = '0;
        bus.l_col_i = '0; bus.u_row_i = '0; bus.result_addr_i = '0; bus.result_valid_i = 1'b0;
        for (int i = 0; i < SIZE; i++) begin
            m_mat[i] = '0; m_l[i] = '0; m_u[i] = '0;
        end

        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_wr_ready",  rowv_t'(bus.host_wr_ready_o), rowv_t'(1));
        chk("rst_rd_ready",  rowv_t'(bus.host_rd_ready_o), rowv_t'(1));
        chk("rst_busy",      rowv_t'(bus.busy_o), rowv_t'(0));
        chk("rst_done",      rowv_t'(bus.done_o), rowv_t'(0));
        chk("rst_start",     rowv_t'(bus.lu_start_o), rowv_t'(0));
        chk("rst_flush",     rowv_t'(bus.lu_flush_o), rowv_t'(0));
        chk("rst_mat_valid", rowv_t'(bus.mat_row_valid_o), rowv_t'(0));
        chk("rst_mat_row",   bus.mat_row_o, rowv_t'(0));
        chk("rst_out_ready", rowv_t'(bus.mat_row_out_ready_o), rowv_t'(0));

        // Incomplete load: go must be ignored.
        for (int i = 0; i < 3; i++) host_write(i, mk_row(i));
        go_pulse();
        chk("partial_go_start", rowv_t'(bus.lu_start_o), rowv_t'(0));
        chk("partial_go_busy",  rowv_t'(bus.busy_o), rowv_t'(0));
        host_write(3, mk_row(3));
        go_pulse();
        chk("go_start",       rowv_t'(bus.lu_start_o), rowv_t'(1));
        chk("go_busy",        rowv_t'(bus.busy_o), rowv_t'(1));
        chk("go_wr_ready",    rowv_t'(bus.host_wr_ready_o), rowv_t'(0));
        chk("go_rd_ready",    rowv_t'(bus.host_rd_ready_o), rowv_t'(0));
        chk("go_res_ready",   rowv_t'(bus.result_out_ready_o), rowv_t'(1));
        tick();
        chk("start_one_cycle", rowv_t'(bus.lu_start_o), rowv_t'(0));

        // Host requests in RUN are dropped.
        bus.host_rd_valid_i = 1'b1; bus.host_rd_sel_i = 2'd0; bus.host_rd_addr_i = '0;
        bus.host_wr_valid_i = 1'b1; bus.host_wr_addr_i = '0; bus.host_wr_row_i = rand_row();
        tick();
        bus.host_rd_valid_i = 1'b0; bus.host_wr_valid_i = 1'b0;

        eng_read(2); tick();
        eng_read(3); tick();
        bus.mat_row_read_addr_valid_i = 1'b0;
        tick();

        // Same-cycle read and write-back of row 1.
        eng_read(1);
        bus.mat_row_valid_i = 1'b1; bus.mat_row_write_addr_i = AW'(1); bus.mat_row_i = aa;
        m_mat[1] = aa;
        tick();
        bus.mat_row_valid_i = 1'b0;
        eng_read(1); tick();
        eng_read(0); tick();
        bus.mat_row_read_addr_valid_i = 1'b0;
        tick();
        chk("mat_row_hold", bus.mat_row_o, m_mat[0]);

        for (int k = 0; k < 5; k++) begin
            send_result(seq[k]);
            chk("done_after_result", rowv_t'(bus.done_o), rowv_t'(k == 4));
        end
        chk("done_busy",     rowv_t'(bus.busy_o), rowv_t'(0));
        chk("done_wr_ready", rowv_t'(bus.host_wr_ready_o), rowv_t'(0));
        chk("done_rd_ready", rowv_t'(bus.host_rd_ready_o), rowv_t'(1));
        host_read(1, 0);
        host_read(2, 3);
        host_read(0, 1);
        host_read(3, 2);
        tick(); tick();

        bus.clear_i = 1'b1; tick(); bus.clear_i = 1'b0;
        chk("clear_done",     rowv_t'(bus.done_o), rowv_t'(0));
        chk("clear_wr_ready", rowv_t'(bus.host_wr_ready_o), rowv_t'(1));
        go_pulse();
        chk("cleared_go_start", rowv_t'(bus.lu_start_o), rowv_t'(0));
        for (int i = 0; i < SIZE; i++) host_write(i, mk_row(i + 8));
        go_pulse();
        chk("go2_start", rowv_t'(bus.lu_start_o), rowv_t'(1));

        // Abort arriving with the final result wins.
        for (int k = 0; k < 3; k++) send_result(k);
        bus.abort_i = 1'b1;
        send_result(3);
        bus.abort_i = 1'b0;
        chk("abort_flush",    rowv_t'(bus.lu_flush_o), rowv_t'(1));
        chk("abort_busy",     rowv_t'(bus.busy_o), rowv_t'(0));
        chk("abort_done",     rowv_t'(bus.done_o), rowv_t'(0));
        chk("abort_wr_ready", rowv_t'(bus.host_wr_ready_o), rowv_t'(1));
        tick();
        chk("flush_one_cycle", rowv_t'(bus.lu_flush_o), rowv_t'(0));
        chk("abort_done_late", rowv_t'(bus.done_o), rowv_t'(0));

        // IDLE read and write of the same row in one cycle returns the old row.
        nr = rand_row();
        host_q.push_back(m_mat[2]);
        bus.host_rd_valid_i = 1'b1; bus.host_rd_sel_i = 2'd0; bus.host_rd_addr_i = AW'(2);
        bus.host_wr_valid_i = 1'b1; bus.host_wr_addr_i = AW'(2); bus.host_wr_row_i = nr;
        m_mat[2] = nr;
        tick();
        bus.host_rd_valid_i = 1'b0; bus.host_wr_valid_i = 1'b0;
        host_read(0, 2);
        tick();

        go_pulse();
        chk("kept_mask_start", rowv_t'(bus.lu_start_o), rowv_t'(1));
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < SIZE; i++) begin
            m_mat[i] = '0; m_l[i] = '0; m_u[i] = '0;
        end
        chk("midrun_rst_flush", rowv_t'(bus.lu_flush_o), rowv_t'(0));
        chk("midrun_rst_busy",  rowv_t'(bus.busy_o), rowv_t'(0));
        chk("midrun_rst_ready", rowv_t'(bus.host_wr_ready_o), rowv_t'(1));
        host_read(0, 2);
        host_read(1, 0);
        host_read(2, 3);
        tick(); tick(); tick();
        chk("host_q_drained", rowv_t'(host_q.size()), rowv_t'(0));
        chk("eng_q_drained",  rowv_t'(eng_q.size()), rowv_t'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
